unidade_controle_multiciclo: RTL and testbench
==============================================

# unidade_controle_multiciclo

- Moore/Mealy FSM that sequences the multi-cycle RV32I datapath (`parte_operativa_multiciclo`) over one shared instruction/data memory.
- Supported instructions: R-type ALU, I-type ALU, LW, SW, BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL.
- Per-state outputs: mux selects, register/memory enables and ALUControl.
- Handshakes with the unified memory through `mem_req`/`mem_ready`; counts retired instructions.

## Interface
Parameters
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports
- `clk` input 1: single clock; everything is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 7: Instr[6:0] from the instruction register.
- `funct3` input 3: Instr[14:12].
- `funct7` input 7: Instr[31:25].
- `Zero` input 1: ALU result == 0, from the datapath.
- `mem_ready` input 1: memory completes the current access this cycle.
- `mem_req` output 1: memory access requested.
- `AdrSrc` output 1: 0 selects PC, 1 selects ALUOut as the memory address.
- `MemWrite` output 1: write RD2 (B register) to memory.
- `IRWrite` output 1: load IR and OldPC.
- `PCWrite` output 1: load PC with Result.
- `RegWrite` output 1: write Result to rd.
- `ResultSrc` output 2: 00 ALUOut, 01 Data register, 10 ALUResult.
- `ALUSrcA` output 2: 00 PC, 01 OldPC, 10 A register.
- `ALUSrcB` output 2: 00 B register, 01 ImmExt, 10 constant 4.
- `ALUControl` output 4: codebase encoding (0010 add, 0110 sub, 0000 and, 0001 or, 0100 xor, 0011 sll, 0101 srl, 1001 sra, 0111 slt, 1000 sltu).
- `illegal_instr` output 1: sticky error flag.
- `instret` output INSTRET_W: retired-instruction count.

## Operation
States and transitions:
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - If mem_ready: IRWrite=1, PCWrite=1, go to DECODE.
  - Else hold in FETCH with IRWrite=PCWrite=0.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/JAL target into ALUOut).
  - Next state by opcode: 0000011/0100011→MEMADR, 0110011→EXECUTER, 0010011→EXECUTEI, 1100011→BRANCH, 1101111→JAL, other→ERROR.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD if opcode is a load, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire, go to FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. Wait for mem_ready, then retire and go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUControl from funct3/funct7[5], go to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUControl from funct3. funct7[5] is used only for shifts (srai); addi never decodes as sub. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire, go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, go to ALUWB (rd ← OldPC+4).
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, retire, go to FETCH.
  - ALU op: sub for beq/bne, slt for blt/bge, sltu for bltu/bgeu.
  - PCWrite (Mealy on Zero): beq Zero; bne !Zero; blt/bltu !Zero; bge/bgeu Zero.
  - funct3 010/011 → ERROR.
- ERROR: all enables 0, illegal_instr=1. Leaves only on reset.

Output and counter rules:
- Any enable not listed for a state is 0.
- Select fields not listed are don't-care and are driven 00.
- Illegal funct3/funct7 combinations for R-type, and SW/LW with funct3≠010, go to ERROR from EXECUTER/MEMADR.
- Retire means `instret` += 1, wrapping modulo 2^INSTRET_W.

## Timing
- While `reset` is high, all outputs are 0 (combinational gating).
- At the edge with `reset` high: state←FETCH, instret←0, illegal_instr←0.
- The first FETCH request occurs in the first cycle after reset falls.
- Reset mid-access wins. A pending mem_req drops in the same cycle; the memory must tolerate an abandoned request.
- Cycle counts with zero wait states:
  - LW 5 cycles.
  - SW, R-type, I-type and JAL 4 cycles.
  - Branch 3 cycles.
- Each cycle with mem_req=1 and mem_ready=0 adds exactly one cycle.
- `mem_req` stays high continuously until mem_ready. Outputs must not change while waiting.
- mem_ready sampled while mem_req=0 is ignored.
- `instret` updates at the clock edge that leaves the retiring state.
- ALUControl is combinational from state and IR fields. IR is stable from DECODE to retire.

## Structure
- Package `riscv_pkg` holds:
  - opcode constants;
  - ALUControl codes, including the new SRA 1001, which the datapath ULA also adopts;
  - ResultSrc/ALUSrcA/ALUSrcB select codes;
  - the state enum.
- One sub-module, `decodificador_ula`: combinational {state class, funct3, funct7[5]} → ALUControl and illegal-funct flag.
- FSM, branch-condition logic and instret counter live in the top.

## Test plan
- Reset and fetch:
  - Hold reset 3 cycles → all outputs 0, instret=0.
  - Release with mem_ready=1 → FETCH asserts IRWrite, PCWrite, mem_req, ALUSrcB=10, ALUControl=0010.
- Load/store sequencing:
  - LW (opcode 0000011, funct3 010) with mem_ready low 2 cycles in MEMREAD → 7 cycles total. MEMWB has ResultSrc=01 and RegWrite=1; instret 0→1.
  - SW with mem_ready=1 → MemWrite and AdrSrc=1 for exactly 1 cycle; 4 cycles total.
- Branches:
  - BEQ with Zero=1 → PCWrite=1 in BRANCH.
  - BNE with Zero=1 → PCWrite=0.
  - BLT issues ALUControl=0111 and takes the branch on Zero=0.
  - BGEU issues 1000 and takes the branch on Zero=1.
- R-type and JAL:
  - sub (funct7 0100000) → ALUControl 0110.
  - sll → 0011.
  - srai (I-type, funct7 0100000) → 1001.
  - addi with Instr[30]=1 → 0010.
  - JAL asserts PCWrite in JAL, then RegWrite in ALUWB.
- Error handling:
  - Opcode 0x7F → ERROR after DECODE, illegal_instr=1 held for 20 cycles with all enables 0.
  - Reset clears it and the next cycle fetches.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the multi-cycle RV32I control
//               path: opcode values, ALUControl codes, datapath select codes,
//               the controller state enum and the ALU-decode class.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Opcodes (Instr[6:0])
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    // ALUControl encoding shared with the datapath ULA
    localparam logic [3:0] c_alu_and  = 4'b0000;
    localparam logic [3:0] c_alu_or   = 4'b0001;
    localparam logic [3:0] c_alu_add  = 4'b0010;
    localparam logic [3:0] c_alu_sll  = 4'b0011;
    localparam logic [3:0] c_alu_xor  = 4'b0100;
    localparam logic [3:0] c_alu_srl  = 4'b0101;
    localparam logic [3:0] c_alu_sub  = 4'b0110;
    localparam logic [3:0] c_alu_slt  = 4'b0111;
    localparam logic [3:0] c_alu_sltu = 4'b1000;
    localparam logic [3:0] c_alu_sra  = 4'b1001;

    // ResultSrc selects
    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_data      = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

    // ALUSrcA selects
    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_a     = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] c_srcb_b    = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    // Which field interpretation the ALU decoder applies
    typedef enum logic [1:0] {
        CLS_ADD    = 2'd0,
        CLS_RTYPE  = 2'd1,
        CLS_ITYPE  = 2'd2,
        CLS_BRANCH = 2'd3
    } alu_class_t;

endpackage
`default_nettype wire

// File: rtl/decodificador_ula.sv
`default_nettype none
// ============================================================================
// Module      : decodificador_ula
// Description : Combinational ALU decoder. Maps {class, funct3, funct7[5]}
//               onto ALUControl and flags funct combinations that have no
//               meaning for the class.
//   i_alu_class     : interpretation (plain add, R-type, I-type, branch)
//   i_funct3        : Instr[14:12]
//   i_funct7_b5     : Instr[30]
//   o_alu_control   : ALU operation code
//   o_illegal_funct : funct fields invalid for this class
// Revision    : 1.0 - initial release
// ============================================================================
module decodificador_ula
    import riscv_pkg::*;
(
    input  alu_class_t  i_alu_class,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_b5,
    output logic [3:0]  o_alu_control,
    output logic        o_illegal_funct
);

    always_comb begin
        o_alu_control   = c_alu_add;
        o_illegal_funct = 1'b0;
        case (i_alu_class)
            CLS_RTYPE, CLS_ITYPE: begin
                case (i_funct3)
                    3'b000: begin
                        // Only R-type can encode sub; addi with Instr[30]=1 is still add
                        if (i_alu_class == CLS_RTYPE && i_funct7_b5)
                            o_alu_control = c_alu_sub;
                        else
                            o_alu_control = c_alu_add;
                    end
                    3'b001:  o_alu_control = c_alu_sll;
                    3'b010:  o_alu_control = c_alu_slt;
                    3'b011:  o_alu_control = c_alu_sltu;
                    3'b100:  o_alu_control = c_alu_xor;
                    3'b101:  o_alu_control = i_funct7_b5 ? c_alu_sra : c_alu_srl;
                    3'b110:  o_alu_control = c_alu_or;
                    default: o_alu_control = c_alu_and;
                endcase
                // In R-type, Instr[30] is meaningful only for add/sub and srl/sra
                if (i_alu_class == CLS_RTYPE && i_funct7_b5 &&
                    i_funct3 != 3'b000 && i_funct3 != 3'b101)
                    o_illegal_funct = 1'b1;
            end
            CLS_BRANCH: begin
                case (i_funct3)
                    3'b000, 3'b001: o_alu_control = c_alu_sub;
                    3'b100, 3'b101: o_alu_control = c_alu_slt;
                    3'b110, 3'b111: o_alu_control = c_alu_sltu;
                    default: begin
                        o_alu_control   = c_alu_sub;
                        o_illegal_funct = 1'b1;
                    end
                endcase
            end
            default: o_alu_control = c_alu_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo
// Description : Multi-cycle RV32I controller sequencing the shared-memory
//               datapath. Supports R/I-type ALU, LW, SW, conditional branches
//               and JAL; handshakes memory via mem_req/mem_ready and counts
//               retired instructions.
//   clk, reset      : clock, synchronous active-high reset
//   opcode/funct3/funct7 : IR fields; Zero : ALU result is zero
//   mem_ready       : memory completes the current access this cycle
//   mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite : datapath controls
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl : datapath selects / ALU op
//   illegal_instr   : sticky error flag; instret : retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_multiciclo
    import riscv_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUControl,
    output logic                 illegal_instr,
    output logic [INSTRET_W-1:0] instret
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [INSTRET_W-1:0]   r_instret;
    logic                   r_illegal;

    alu_class_t             w_alu_class;
    logic [3:0]             w_dec_alu;
    logic                   w_dec_illegal;
    logic                   w_funct7_ok;
    logic                   w_branch_taken;
    logic                   w_retire;

    logic                   w_mem_req, w_adr_src, w_mem_write;
    logic                   w_ir_write, w_pc_write, w_reg_write;
    logic [1:0]             w_result_src, w_alu_src_a, w_alu_src_b;
    logic [3:0]             w_alu_control;

    always_comb begin
        case (r_state)
            S_EXECUTER: w_alu_class = CLS_RTYPE;
            S_EXECUTEI: w_alu_class = CLS_ITYPE;
            S_BRANCH:   w_alu_class = CLS_BRANCH;
            default:    w_alu_class = CLS_ADD;
        endcase
    end

    decodificador_ula u_decodificador_ula (
        .i_alu_class     (w_alu_class),
        .i_funct3        (funct3),
        .i_funct7_b5     (funct7[5]),
        .o_alu_control   (w_dec_alu),
        .o_illegal_funct (w_dec_illegal)
    );

    // R-type funct7 must be 0000000 or 0100000; bit 5 is judged by the decoder
    assign w_funct7_ok = ((funct7 & 7'b1011111) == 7'b0000000);

    // sub result zero means equal; slt/sltu result zero means "not less than"
    always_comb begin
        case (funct3)
            3'b000:         w_branch_taken = Zero;
            3'b001:         w_branch_taken = ~Zero;
            3'b100, 3'b110: w_branch_taken = ~Zero;
            3'b101, 3'b111: w_branch_taken = Zero;
            default:        w_branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state  = r_state;
        w_retire      = 1'b0;
        w_mem_req     = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_control = 4'b0000;
        case (r_state)
            S_FETCH: begin
                w_mem_req     = 1'b1;
                w_alu_src_a   = c_srca_pc;
                w_alu_src_b   = c_srcb_four;
                w_alu_control = c_alu_add;
                w_result_src  = c_res_aluresult;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute OldPC + imm so branch/JAL find the target in ALUOut
                w_alu_src_a   = c_srca_oldpc;
                w_alu_src_b   = c_srcb_imm;
                w_alu_control = c_alu_add;
                case (opcode)
                    c_op_load, c_op_store: w_next_state = S_MEMADR;
                    c_op_rtype:            w_next_state = S_EXECUTER;
                    c_op_itype:            w_next_state = S_EXECUTEI;
                    c_op_branch:           w_next_state = S_BRANCH;
                    c_op_jal:              w_next_state = S_JAL;
                    default:               w_next_state = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a   = c_srca_a;
                w_alu_src_b   = c_srcb_imm;
                w_alu_control = c_alu_add;
                if (funct3 != 3'b010)
                    w_next_state = S_ERROR;
                else if (opcode == c_op_load)
                    w_next_state = S_MEMREAD;
                else
                    w_next_state = S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_mem_req    = 1'b1;
                w_adr_src    = 1'b1;
                w_result_src = c_res_aluout;
                if (mem_ready)
                    w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = c_res_data;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_EXECUTER: begin
                w_alu_src_a   = c_srca_a;
                w_alu_src_b   = c_srcb_b;
                w_alu_control = w_dec_alu;
                if (w_dec_illegal || !w_funct7_ok)
                    w_next_state = S_ERROR;
                else
                    w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a   = c_srca_a;
                w_alu_src_b   = c_srcb_imm;
                w_alu_control = w_dec_alu;
                w_next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = c_res_aluout;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd
                w_alu_src_a   = c_srca_oldpc;
                w_alu_src_b   = c_srcb_four;
                w_alu_control = c_alu_add;
                w_result_src  = c_res_aluout;
                w_pc_write    = 1'b1;
                w_next_state  = S_ALUWB;
            end
            S_BRANCH: begin
                w_alu_src_a   = c_srca_a;
                w_alu_src_b   = c_srcb_b;
                w_alu_control = w_dec_alu;
                w_result_src  = c_res_aluout;
                if (w_dec_illegal) begin
                    w_next_state = S_ERROR;
                end else begin
                    w_pc_write   = w_branch_taken;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_ERROR: w_next_state = S_ERROR;
            default: w_next_state = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_retire)
                r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
            if (w_next_state == S_ERROR)
                r_illegal <= 1'b1;
        end
    end

    // Reset forces every output low immediately, abandoning any pending access
    assign mem_req       = w_mem_req   & ~reset;
    assign AdrSrc        = w_adr_src   & ~reset;
    assign MemWrite      = w_mem_write & ~reset;
    assign IRWrite       = w_ir_write  & ~reset;
    assign PCWrite       = w_pc_write  & ~reset;
    assign RegWrite      = w_reg_write & ~reset;
    assign ResultSrc     = reset ? 2'b00 : w_result_src;
    assign ALUSrcA       = reset ? 2'b00 : w_alu_src_a;
    assign ALUSrcB       = reset ? 2'b00 : w_alu_src_b;
    assign ALUControl    = reset ? 4'b0000 : w_alu_control;
    assign illegal_instr = r_illegal & ~reset;
    assign instret       = reset ? '0 : r_instret;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_multiciclo
// Description : Directed self-checking bench for the multi-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_multiciclo;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControl;
    logic        illegal_instr;
    logic [31:0] instret;

    unidade_controle_multiciclo #(.INSTRET_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .Zero         (Zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .illegal_instr(illegal_instr),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, illegal_instr}
    logic [12:0] w_snap;
    assign w_snap = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, illegal_instr};

    localparam logic [12:0] c_e_zero   = 13'b0_0_0_0_0_0_00_00_00_0;
    localparam logic [12:0] c_e_fetch  = 13'b1_0_0_1_1_0_10_00_10_0;
    localparam logic [12:0] c_e_fetchw = 13'b1_0_0_0_0_0_10_00_10_0;
    localparam logic [12:0] c_e_decode = 13'b0_0_0_0_0_0_00_01_01_0;
    localparam logic [12:0] c_e_memadr = 13'b0_0_0_0_0_0_00_10_01_0;
    localparam logic [12:0] c_e_memrd  = 13'b1_1_0_0_0_0_00_00_00_0;
    localparam logic [12:0] c_e_memwb  = 13'b0_0_0_0_0_1_01_00_00_0;
    localparam logic [12:0] c_e_memwr  = 13'b1_1_1_0_0_0_00_00_00_0;
    localparam logic [12:0] c_e_exr    = 13'b0_0_0_0_0_0_00_10_00_0;
    localparam logic [12:0] c_e_exi    = 13'b0_0_0_0_0_0_00_10_01_0;
    localparam logic [12:0] c_e_aluwb  = 13'b0_0_0_0_0_1_00_00_00_0;
    localparam logic [12:0] c_e_jal    = 13'b0_0_0_0_1_0_00_01_10_0;
    localparam logic [12:0] c_e_br_t   = 13'b0_0_0_0_1_0_00_10_00_0;
    localparam logic [12:0] c_e_br_n   = 13'b0_0_0_0_0_0_00_10_00_0;
    localparam logic [12:0] c_e_error  = 13'b0_0_0_0_0_0_00_00_00_1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cyc;
    int          exp_ret = 0;
    logic [12:0] snap [0:31];
    logic [3:0]  alu  [0:31];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Runs one instruction starting mid-cycle in FETCH; stops mid-cycle in the next FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input int waits);
        int wcnt;
        opcode = op; funct3 = f3; funct7 = f7; Zero = z;
        wcnt   = waits;
        n_cyc  = 0;
        for (int i = 0; i < 32; i++) begin
            if (mem_req && AdrSrc) begin
                if (wcnt > 0) begin
                    mem_ready = 1'b0;
                    wcnt--;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            snap[i] = w_snap;
            alu[i]  = ALUControl;
            n_cyc   = i + 1;
            tick();
            if (mem_req && !AdrSrc) break;
        end
    endtask

    task automatic verify(input string tag, input int n_exp,
                          input logic [12:0] e0, input logic [12:0] e1, input logic [12:0] e2,
                          input logic [12:0] e3, input logic [12:0] e4, input logic [12:0] e5,
                          input logic [12:0] e6);
        logic [12:0] e [0:6];
        e = '{e0, e1, e2, e3, e4, e5, e6};
        check({tag, "_cycles"}, n_cyc, n_exp);
        for (int k = 0; k < n_exp; k++)
            check($sformatf("%s_c%0d", tag, k), {19'd0, snap[k]}, {19'd0, e[k]});
        check({tag, "_instret"}, instret, exp_ret);
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; Zero = 1'b0; mem_ready = 1'b1;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_ctl%0d", i), {19'd0, w_snap}, {19'd0, c_e_zero});
            check($sformatf("reset_alu%0d", i), {28'd0, ALUControl}, 32'd0);
        end
        check("reset_instret", instret, 32'd0);
        reset = 1'b0;
        #1;
        check("fetch_alu", {28'd0, ALUControl}, 32'h2);

        // LW, two wait states in MEMREAD
        exp_ret++;
        run_instr(7'b0000011, 3'b010, 7'b0, 1'b0, 2);
        verify("lw", 7, c_e_fetch, c_e_decode, c_e_memadr, c_e_memrd, c_e_memrd, c_e_memrd, c_e_memwb);

        // SW, no wait
        exp_ret++;
        run_instr(7'b0100011, 3'b010, 7'b0, 1'b0, 0);
        verify("sw", 4, c_e_fetch, c_e_decode, c_e_memadr, c_e_memwr, '0, '0, '0);

        // Branches
        exp_ret++;
        run_instr(7'b1100011, 3'b000, 7'b0, 1'b1, 0);
        verify("beq_z1", 3, c_e_fetch, c_e_decode, c_e_br_t, '0, '0, '0, '0);
        check("beq_alu", {28'd0, alu[2]}, 32'h6);
        exp_ret++;
        run_instr(7'b1100011, 3'b001, 7'b0, 1'b1, 0);
        verify("bne_z1", 3, c_e_fetch, c_e_decode, c_e_br_n, '0, '0, '0, '0);
        check("bne_alu", {28'd0, alu[2]}, 32'h6);
        exp_ret++;
        run_instr(7'b1100011, 3'b100, 7'b0, 1'b0, 0);
        verify("blt_z0", 3, c_e_fetch, c_e_decode, c_e_br_t, '0, '0, '0, '0);
        check("blt_alu", {28'd0, alu[2]}, 32'h7);
        exp_ret++;
        run_instr(7'b1100011, 3'b111, 7'b0, 1'b1, 0);
        verify("bgeu_z1", 3, c_e_fetch, c_e_decode, c_e_br_t, '0, '0, '0, '0);
        check("bgeu_alu", {28'd0, alu[2]}, 32'h8);
        exp_ret++;
        run_instr(7'b1100011, 3'b101, 7'b0, 1'b0, 0);
        verify("bge_z0", 3, c_e_fetch, c_e_decode, c_e_br_n, '0, '0, '0, '0);

        // R-type / I-type ALU ops
        exp_ret++;
        run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0);
        verify("sub", 4, c_e_fetch, c_e_decode, c_e_exr, c_e_aluwb, '0, '0, '0);
        check("sub_alu", {28'd0, alu[2]}, 32'h6);
        exp_ret++;
        run_instr(7'b0110011, 3'b001, 7'b0, 1'b0, 0);
        verify("sll", 4, c_e_fetch, c_e_decode, c_e_exr, c_e_aluwb, '0, '0, '0);
        check("sll_alu", {28'd0, alu[2]}, 32'h3);
        exp_ret++;
        run_instr(7'b0010011, 3'b101, 7'b0100000, 1'b0, 0);
        verify("srai", 4, c_e_fetch, c_e_decode, c_e_exi, c_e_aluwb, '0, '0, '0);
        check("srai_alu", {28'd0, alu[2]}, 32'h9);
        exp_ret++;
        run_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0, 0);
        verify("addi_b30", 4, c_e_fetch, c_e_decode, c_e_exi, c_e_aluwb, '0, '0, '0);
        check("addi_alu", {28'd0, alu[2]}, 32'h2);

        // JAL
        exp_ret++;
        run_instr(7'b1101111, 3'b000, 7'b0, 1'b0, 0);
        verify("jal", 4, c_e_fetch, c_e_decode, c_e_jal, c_e_aluwb, '0, '0, '0);
        check("jal_alu", {28'd0, alu[2]}, 32'h2);

        // Illegal opcode: ERROR held with all enables low
        opcode = 7'h7F; mem_ready = 1'b1;
        #1;
        check("ill_fetch", {19'd0, w_snap}, {19'd0, c_e_fetch});
        tick();
        check("ill_decode", {19'd0, w_snap}, {19'd0, c_e_decode});
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("ill_hold%0d", i), {19'd0, w_snap}, {19'd0, c_e_error});
        end
        check("ill_instret", instret, exp_ret);

        // Reset gates outputs at once, then the next cycle fetches
        reset = 1'b1;
        #1;
        check("ill_rst_gate", {19'd0, w_snap}, {19'd0, c_e_zero});
        tick();
        reset = 1'b0;
        #1;
        check("ill_rst_fetch", {19'd0, w_snap}, {19'd0, c_e_fetch});
        check("ill_rst_instret", instret, 32'd0);

        // Fetch wait state holds outputs; reset mid-access drops mem_req immediately
        mem_ready = 1'b0;
        #1;
        check("fetch_wait0", {19'd0, w_snap}, {19'd0, c_e_fetchw});
        tick();
        check("fetch_wait1", {19'd0, w_snap}, {19'd0, c_e_fetchw});
        reset = 1'b1;
        #1;
        check("abandon_req", {19'd0, w_snap}, {19'd0, c_e_zero});
        tick();
        reset = 1'b0;

        // R-type AND with funct7=0100000 goes to ERROR from EXECUTER
        opcode = 7'b0110011; funct3 = 3'b111; funct7 = 7'b0100000; mem_ready = 1'b1;
        #1;
        check("rill_fetch", {19'd0, w_snap}, {19'd0, c_e_fetch});
        tick();
        check("rill_decode", {19'd0, w_snap}, {19'd0, c_e_decode});
        tick();
        check("rill_exec", {19'd0, w_snap}, {19'd0, c_e_exr});
        tick();
        check("rill_error", {19'd0, w_snap}, {19'd0, c_e_error});
        check("rill_instret", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
